// File: rtl/gfx_mem_exec_unit.sv
// Instruction executor driving the working RAM, the frame-buffer RAM and the VGA pixel stream.
// Latency: NOP 1, DRAW 2, MEMREAD/MEMWRITE/DISPLAY 1+RAM_LAT, FILL W*H+1, SCAN W*H+RAM_LAT cycles after accept.
// Backpressure: one instruction in flight; start is ignored while ready=0. Optional feature macro: BOUNDS_CHECK_EN.
module gfx_mem_exec_unit #(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_W   = 4,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FB_ADDR_W  = 15,
    parameter int MEM_ADDR_W = 16,
    parameter int MEM_DATA_W = 12,
    parameter int RAM_LAT    = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [INSTR_W-1:0]    instruction,
    output logic                  ready,
    output logic                  done,
    output logic [MEM_DATA_W-1:0] result,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  plot,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [COLOUR_W-1:0]   fb_wdata,
    output logic                  fb_we,
    input  logic [COLOUR_W-1:0]   fb_rdata,
    output logic                  error
);

    localparam int NPIX  = SCREEN_W * SCREEN_H;
    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [OPCODE_W-1:0] OP_DRAW  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_MEMRD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_MEMWR = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_DISP  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_FILL  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_SCAN  = OPCODE_W'(6);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOOP} state_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [INSTR_W-1:0]    instr_q;
    logic [FB_ADDR_W-1:0]  pix_q;
    logic [X_W-1:0]        sx_q, x_q;
    logic [Y_W-1:0]        sy_q, y_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic [MEM_DATA_W-1:0] result_q;
    logic                  vp_q [RAM_LAT];
    logic [X_W-1:0]        xp_q [RAM_LAT];
    logic [Y_W-1:0]        yp_q [RAM_LAT];

    // Instruction fields, all taken from the latched instruction
    logic [OPCODE_W-1:0]   op_w;
    logic [X_W-1:0]        fx_w;
    logic [Y_W-1:0]        fy_w;
    logic [COLOUR_W-1:0]   fcol_w;
    logic                  fwr_w;
    logic [FB_ADDR_W-1:0]  pix_addr_w;
    assign op_w       = instr_q[INSTR_W-1 -: OPCODE_W];
    assign fx_w       = instr_q[X_W-1:0];
    assign fy_w       = instr_q[X_W+Y_W-1:X_W];
    assign fcol_w     = instr_q[X_W+Y_W+COLOUR_W-1 -: COLOUR_W];
    assign fwr_w      = instr_q[X_W+Y_W+COLOUR_W];
    assign pix_addr_w = FB_ADDR_W'(fy_w) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(fx_w);

    logic is_draw, is_rd, is_wr, is_disp, is_fill, is_scan, streaming;
    assign is_draw   = (op_w == OP_DRAW);
    assign is_rd     = (op_w == OP_MEMRD);
    assign is_wr     = (op_w == OP_MEMWR);
    assign is_disp   = (op_w == OP_DISP);
    assign is_fill   = (op_w == OP_FILL);
    assign is_scan   = (op_w == OP_SCAN);
    assign streaming = is_fill | is_scan;

    logic in_stream, last_pix, scan_issue, fin, rd_done, disp_plot, scan_plot, in_bounds;
    assign in_stream  = ((state_q == S_ISSUE) || (state_q == S_LOOP)) && streaming;
    assign last_pix   = (pix_q == FB_ADDR_W'(NPIX - 1));
    assign scan_issue = in_stream && is_scan;
    assign fin        = (state_q == S_WAIT) && (lat_q == '0);
    assign rd_done    = fin && is_rd;
    assign disp_plot  = fin && is_disp && in_bounds;
    assign scan_plot  = vp_q[RAM_LAT-1];

`ifdef BOUNDS_CHECK_EN
    logic error_q;
    assign in_bounds = (int'(fx_w) < SCREEN_W) && (int'(fy_w) < SCREEN_H);
    assign error     = error_q;
    // Sticky flag for any DRAW/DISPLAY aimed off-screen
    always_ff @(posedge clock) begin
        if (!resetn)
            error_q <= 1'b0;
        else if ((state_q == S_ISSUE) && (is_draw || is_disp) && !in_bounds)
            error_q <= 1'b1;
    end
`else
    assign in_bounds = 1'b1;
    assign error     = 1'b0;
`endif

    // State register with the WAIT countdown
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Next state: ISSUE/LOOP choose how long to wait for RAM data before completing
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_ISSUE;
            S_ISSUE, S_LOOP: begin
                if (streaming) begin
                    if (last_pix) begin
                        state_d = S_WAIT;
                        lat_d   = is_scan ? LAT_W'(RAM_LAT - 1) : '0;
                    end else begin
                        state_d = S_LOOP;
                    end
                end else if (is_draw) begin
                    state_d = S_WAIT;
                    lat_d   = '0;
                end else if (is_rd || is_wr || is_disp) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_W'(RAM_LAT - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) state_d = S_IDLE;
                else             lat_d   = lat_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: RAM strobes in ISSUE/LOOP, completion in WAIT; write enables drop in a reset cycle
    always_comb begin
        ready     = (state_q == S_IDLE);
        done      = fin || ((state_q == S_ISSUE) && !(is_draw || is_rd || is_wr || is_disp || streaming));
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        fb_addr   = '0;
        fb_wdata  = '0;
        fb_we     = 1'b0;
        if (state_q == S_ISSUE) begin
            if (is_rd || is_wr) mem_addr = instr_q[MEM_ADDR_W-1:0];
            if (is_wr) begin
                mem_wdata = instr_q[MEM_ADDR_W+MEM_DATA_W-1:MEM_ADDR_W];
                mem_we    = resetn;
            end
            if ((is_draw || is_disp) && in_bounds) fb_addr = pix_addr_w;
            if (is_draw) begin
                fb_wdata = fcol_w;
                fb_we    = fwr_w && in_bounds && resetn;
            end
        end
        if (in_stream) begin
            fb_addr = pix_q;
            if (is_fill) begin
                fb_wdata = fcol_w;
                fb_we    = resetn;
            end
        end
        plot   = disp_plot || scan_plot;
        x      = scan_plot ? xp_q[RAM_LAT-1] : x_q;
        y      = scan_plot ? yp_q[RAM_LAT-1] : y_q;
        colour = plot ? fb_rdata : colour_q;
        result = rd_done ? mem_rdata : result_q;
    end

    // Datapath: instruction latch, raster counters, held results and the SCAN coordinate delay line
    always_ff @(posedge clock) begin
        if (!resetn) begin
            instr_q  <= '0;
            pix_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            result_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                vp_q[i] <= 1'b0;
                xp_q[i] <= '0;
                yp_q[i] <= '0;
            end
        end else begin
            if ((state_q == S_IDLE) && start) begin
                instr_q <= instruction;
                pix_q   <= '0;
                sx_q    <= '0;
                sy_q    <= '0;
            end
            if (in_stream) begin
                pix_q <= pix_q + 1'b1;
                if (sx_q == X_W'(SCREEN_W - 1)) begin
                    sx_q <= '0;
                    sy_q <= sy_q + 1'b1;
                end else begin
                    sx_q <= sx_q + 1'b1;
                end
            end
            if ((state_q == S_ISSUE) && is_disp) begin
                x_q <= fx_w;
                y_q <= fy_w;
            end
            if (rd_done) result_q <= mem_rdata;
            if (plot)    colour_q <= fb_rdata;
            vp_q[0] <= scan_issue;
            xp_q[0] <= sx_q;
            yp_q[0] <= sy_q;
            for (int i = 1; i < RAM_LAT; i++) begin
                vp_q[i] <= vp_q[i-1];
                xp_q[i] <= xp_q[i-1];
                yp_q[i] <= yp_q[i-1];
            end
        end
    end

endmodule
